// File: rtl/wpat_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wpat_tx                                                       |
// | Purpose  : Pattern-word transmitter. Sends bursts of counter,            |
// |            walking-one, LFSR or constant words over valid/ready, with    |
// |            backpressure, abort and a one-cycle completion pulse.         |
// | Options  : WPAT_TX_PARITY_EN adds tx_par, the registered XOR of tx_data. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wpat_tx #(
  parameter int DW = 5,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [BW-1:0] burst_len,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] sent_cnt
`ifdef WPAT_TX_PARITY_EN
  ,
  output logic          tx_par
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_MODE_CNT  = 2'd0;
  localparam logic [1:0] C_MODE_WALK = 2'd1;
  localparam logic [1:0] C_MODE_LFSR = 2'd2;
  localparam logic [1:0] C_MODE_CONST = 2'd3;

  localparam logic [DW-1:0] C_DW_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] C_BW_ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [BW-1:0] r_len;

  state_t        w_state_nxt;
  logic [1:0]    w_mode_nxt;
  logic [BW-1:0] w_len_nxt;
  logic [DW-1:0] w_data_nxt;
  logic          w_valid_nxt;
  logic [BW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_next_word;
  logic [DW-1:0] w_first_word;
  logic [BW-1:0] w_cnt_inc;
  logic          w_hs;

  assign w_hs      = tx_valid && tx_ready;
  assign w_cnt_inc = sent_cnt + C_BW_ONE;

  // A zero seed would freeze walking-one and LFSR, so it is replaced by 1.
  assign w_first_word = ((seed == '0) && ((mode == C_MODE_WALK) || (mode == C_MODE_LFSR)))
                        ? C_DW_ONE : seed;

  // Successor of the current word for the captured pattern mode.
  always_comb begin
    w_next_word = tx_data;
    case (r_mode)
      C_MODE_CNT:   w_next_word = tx_data + C_DW_ONE;
      C_MODE_WALK:  w_next_word = {tx_data[DW-2:0], tx_data[DW-1]};
      C_MODE_LFSR:  w_next_word = {tx_data[DW-2:0], tx_data[DW-1] ^ tx_data[DW-3]};
      C_MODE_CONST: w_next_word = tx_data;
      default:      w_next_word = tx_data;
    endcase
  end

  // Next-state and next-output logic; everything holds unless a rule below fires.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_len_nxt   = r_len;
    w_data_nxt  = tx_data;
    w_valid_nxt = tx_valid;
    w_cnt_nxt   = sent_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_mode_nxt = mode;
          w_len_nxt  = burst_len;
          w_cnt_nxt  = '0;
          if (burst_len != '0) begin
            w_state_nxt = ST_SEND;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_first_word;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        // A handshake coinciding with abort is still counted.
        if (w_hs) begin
          w_cnt_nxt  = w_cnt_inc;
          w_data_nxt = w_next_word;
          if (w_cnt_inc == r_len) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_DONE;
          end
        end
        if (abort) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; busy/done are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_mode   <= 2'd0;
      r_len    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      sent_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_len    <= w_len_nxt;
      tx_data  <= w_data_nxt;
      tx_valid <= w_valid_nxt;
      sent_cnt <= w_cnt_nxt;
      busy     <= (w_state_nxt != ST_IDLE);
      done     <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef WPAT_TX_PARITY_EN
  // Parity is registered alongside tx_data so both change on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_par <= 1'b0;
    end else begin
      tx_par <= ^w_data_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wpat_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wpat_tx                                                    |
// | Purpose  : Self-checking bench for wpat_tx: directed scenarios plus      |
// |            random bursts against a word-index reference model.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wpat_tx;

  localparam int DW = 5;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [DW-1:0] seed;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;
  logic [BW-1:0] sent_cnt;
`ifdef WPAT_TX_PARITY_EN
  logic          tx_par;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: burst phase, beat index and expected registered outputs.
  int            m_ph;      // 0 idle, 1 sending, 2 completion cycle
  int            m_mode;
  logic [DW-1:0] m_seed;
  int            m_len;
  int            m_idx;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_busy;
  logic          m_done;
  int            m_cnt;
  logic          m_rst;

  wpat_tx #(.DW(DW), .BW(BW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt)
`ifdef WPAT_TX_PARITY_EN
    ,
    .tx_par    (tx_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // k-th word of a burst, derived directly from the pattern definitions.
  function automatic logic [DW-1:0] word_at(input int md, input logic [DW-1:0] s, input int k);
    logic [DW-1:0]   f;
    logic [2*DW-1:0] t;
    logic [DW-1:0]   w;
    f = ((s == '0) && (md == 1 || md == 2)) ? DW'(1) : s;
    case (md)
      0: return DW'(int'(f) + k);
      1: begin
        t = {f, f} << (k % DW);
        return t[2*DW-1:DW];
      end
      2: begin
        w = f;
        for (int i = 0; i < k; i++) w = {w[DW-2:0], w[DW-1] ^ w[DW-3]};
        return w;
      end
      default: return f;
    endcase
  endfunction

  // Advance the model by one clock edge given the inputs about to be sampled.
  task automatic model_step(input logic st, input logic ab, input logic rdy, input logic rn);
    m_rst = !rn;
    if (!rn) begin
      m_ph = 0; m_valid = 0; m_data = '0; m_busy = 0; m_done = 0; m_cnt = 0;
      return;
    end
    case (m_ph)
      0: begin
        m_done = 0;
        m_busy = 0;
        if (st) begin
          m_mode = int'(mode); m_seed = seed; m_len = int'(burst_len);
          m_cnt = 0; m_idx = 0; m_busy = 1;
          if (m_len != 0) begin
            m_ph = 1; m_valid = 1; m_data = word_at(m_mode, m_seed, 0);
          end else begin
            m_ph = 2; m_done = 1;
          end
        end
      end
      1: begin
        if (rdy) begin
          m_cnt++; m_idx++;
          m_data = word_at(m_mode, m_seed, m_idx);
          if (m_cnt == m_len) begin
            m_valid = 0; m_ph = 2; m_done = 1;
          end
        end
        if (ab) begin
          m_valid = 0; m_ph = 2; m_done = 1;
        end
      end
      default: begin
        m_ph = 0; m_done = 0; m_busy = 0;
      end
    endcase
  endtask

  task automatic compare();
    check("tx_valid", 32'(tx_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
    if (m_valid || m_rst) begin
      check("tx_data", 32'(tx_data), 32'(m_data));
`ifdef WPAT_TX_PARITY_EN
      check("tx_par", 32'(tx_par), 32'(^m_data));
`endif
    end
  endtask

  // One clock: drive inputs, step the model, sample 1ns after the edge.
  task automatic cycle(input logic st, input logic ab, input logic rdy, input logic rn = 1'b1);
    start = st; abort = ab; tx_ready = rdy; rstn = rn;
    model_step(st, ab, rdy, rn);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drain_ready();
    int c;
    c = 0;
    while (m_ph != 0 && c < 200) begin
      cycle(1'b0, 1'b0, 1'b1);
      c++;
    end
    if (m_ph != 0) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic setup(input logic [1:0] md, input logic [DW-1:0] sd, input logic [BW-1:0] ln);
    mode = md; seed = sd; burst_len = ln;
  endtask

  initial begin
    start = 0; abort = 0; tx_ready = 0; rstn = 0;
    mode = 0; seed = '0; burst_len = '0;
    m_mode = 0; m_seed = '0; m_len = 0; m_idx = 0; m_ph = 0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // Counter wrap: 30,31,0,1
    setup(2'd0, 5'd30, 8'd4);
    cycle(1'b1, 1'b0, 1'b1);
    drain_ready();
    check("wrap_cnt_final", 32'(sent_cnt), 32'd4);

    // LFSR from zero seed: 1,2,4,9,18
    setup(2'd2, 5'd0, 8'd5);
    cycle(1'b1, 1'b0, 1'b1);
    drain_ready();

    // Backpressure on walking-one: held at 3 for two cycles
    setup(2'd1, 5'd3, 8'd3);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check("bp_hold_data", 32'(tx_data), 32'd3);
    drain_ready();
    check("bp_cnt_final", 32'(sent_cnt), 32'd3);

    // Zero-length burst
    setup(2'd0, 5'd9, 8'd0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Abort coinciding with the 3rd handshake
    setup(2'd0, 5'd0, 8'd10);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("abort_beat3_data", 32'(tx_data), 32'd2);
    cycle(1'b0, 1'b1, 1'b1);
    drain_ready();
    check("abort_cnt_final", 32'(sent_cnt), 32'd3);

    // Start while sending is ignored; then reset mid-burst
    setup(2'd1, 5'd1, 8'd20);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Constant pattern after reset: 7 twice
    setup(2'd3, 5'd7, 8'd2);
    cycle(1'b1, 1'b0, 1'b1);
    drain_ready();

    // Random bursts with random backpressure, rare abort and stray starts
    for (int b = 0; b < 60; b++) begin
      int c;
      setup(2'($urandom_range(0, 3)), DW'($urandom), BW'($urandom_range(0, 40)));
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      c = 0;
      while (m_ph != 0 && c < 500) begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 3) != 0));
        c++;
      end
      if (m_ph != 0) check("rand_timeout", 32'd1, 32'd0);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) cycle(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
